// File: rtl/led_seq.sv
// led_seq -- LED effect sequencer.
//
// Accepts one effect command at a time (OFF, SOLID, BLINK, FADE) and drives a
// registered 16-bit PWM codeword ([15:8] red, [7:0] green) for the downstream
// LED stage. Effects advance on a divided "tick" derived from the clock.
//
// Optional feature: define LED_SEQ_FADE_EN to build the FADE effect. Without it,
// the FADE states are absent and cmd_mode=3 behaves exactly as SOLID.
//
// Ports:
//   clock      system clock, rising-edge
//   resetn     asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  block can accept a command (IDLE or SOLID)
//   cmd_mode   0=OFF 1=SOLID 2=BLINK 3=FADE
//   cmd_color  target code, [15:8] red, [7:0] green
//   cmd_count  repetitions for BLINK/FADE, 0 means 16
//   abort      cancel current effect (highest priority)
//   code       registered PWM codeword
//   busy       high in any state other than IDLE or SOLID
//   done       one-cycle pulse when an effect completes
//   state_dbg  current FSM state, for checkers
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1 and abort is 0; mode, color and count are captured on
// that edge. cmd_valid may be held or dropped freely while cmd_ready is 0.
module led_seq #(
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_mode,
  input  logic [15:0] cmd_color,
  input  logic [3:0]  cmd_count,
  input  logic        abort,
  output logic [15:0] code,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_dbg
);

  localparam int              TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [15:0]     BLINK_LAST = 16'(BLINK_TICKS - 1);
  localparam logic [1:0]      MODE_OFF   = 2'd0;
  localparam logic [1:0]      MODE_BLINK = 2'd2;
`ifdef LED_SEQ_FADE_EN
  localparam logic [1:0]      MODE_FADE  = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SOLID     = 3'd1,
    S_BLINK_ON  = 3'd2,
    S_BLINK_OFF = 3'd3,
    S_FADE_UP   = 3'd4,
    S_FADE_DOWN = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   code_q, code_d;
  logic [15:0]   color_q, color_d;
  logic [4:0]    rep_q, rep_d;
  logic [15:0]   blink_q, blink_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          done_q, done_d;
  logic          tick;
  logic          accept;

  assign tick      = (tick_q == TICK_LAST);
  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_SOLID);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = !cmd_ready;
  assign code      = code_q;
  // Masked so done can never coincide with abort.
  assign done      = done_q && !abort;
  assign state_dbg = state_q;

`ifdef LED_SEQ_FADE_EN
  // Per-channel saturating step; no carry between red and green.
  logic [15:0] fade_up, fade_dn;
  assign fade_up = {(code_q[15:8] < color_q[15:8]) ? code_q[15:8] + 8'd1 : code_q[15:8],
                    (code_q[7:0]  < color_q[7:0])  ? code_q[7:0]  + 8'd1 : code_q[7:0]};
  assign fade_dn = {(code_q[15:8] != 8'd0) ? code_q[15:8] - 8'd1 : code_q[15:8],
                    (code_q[7:0]  != 8'd0) ? code_q[7:0]  - 8'd1 : code_q[7:0]};
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      color_q <= '0;
      rep_q   <= '0;
      blink_q <= '0;
      tick_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      color_q <= color_d;
      rep_q   <= rep_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    color_d = color_q;
    rep_d   = rep_q;
    blink_d = blink_q;
    done_d  = 1'b0;
    tick_d  = tick ? '0 : tick_q + TW'(1);

    if (abort) begin
      state_d = S_IDLE;
      code_d  = '0;
      tick_d  = '0;
      blink_d = '0;
      rep_d   = '0;
    end else if (accept) begin
      // Restart the tick phase so every effect sees full-length ticks.
      tick_d  = '0;
      blink_d = '0;
      color_d = cmd_color;
      case (cmd_mode)
        MODE_OFF: begin
          state_d = S_IDLE;
          code_d  = '0;
          done_d  = 1'b1;
        end
        MODE_BLINK: begin
          state_d = S_BLINK_ON;
          code_d  = cmd_color;
          rep_d   = (cmd_count == 4'd0) ? 5'd16 : {1'b0, cmd_count};
        end
`ifdef LED_SEQ_FADE_EN
        MODE_FADE: begin
          state_d = S_FADE_UP;
          code_d  = '0;
          rep_d   = (cmd_count == 4'd0) ? 5'd16 : {1'b0, cmd_count};
        end
`endif
        default: begin
          // SOLID (and FADE when the fade feature is not built).
          state_d = S_SOLID;
          code_d  = cmd_color;
          done_d  = 1'b1;
        end
      endcase
    end else if (tick) begin
      case (state_q)
        S_BLINK_ON: begin
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            state_d = S_BLINK_OFF;
            code_d  = '0;
          end else begin
            blink_d = blink_q + 16'd1;
          end
        end
        S_BLINK_OFF: begin
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            if (rep_q == 5'd1) begin
              state_d = S_IDLE;
              rep_d   = '0;
              done_d  = 1'b1;
            end else begin
              rep_d   = rep_q - 5'd1;
              state_d = S_BLINK_ON;
              code_d  = color_q;
            end
          end else begin
            blink_d = blink_q + 16'd1;
          end
        end
`ifdef LED_SEQ_FADE_EN
        S_FADE_UP: begin
          // Turn around on the same tick the target is reached.
          code_d = fade_up;
          if (fade_up == color_q) state_d = S_FADE_DOWN;
        end
        S_FADE_DOWN: begin
          code_d = fade_dn;
          if (fade_dn == 16'd0) begin
            if (rep_q == 5'd1) begin
              state_d = S_IDLE;
              rep_d   = '0;
              done_d  = 1'b1;
            end else begin
              rep_d   = rep_q - 5'd1;
              state_d = S_FADE_UP;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_seq.sv
// tb_led_seq -- randomized scoreboard bench for led_seq (TICK_DIV=4,
// BLINK_TICKS=2). For every command the expected per-cycle output trace is
// derived from the effect rules (phase lengths, per-tick channel ramps) and
// queued; a monitor pops one entry per cycle and compares.
module tb_led_seq;
  localparam int TICK_DIV    = 4;
  localparam int BLINK_TICKS = 2;
  localparam int PHASE       = TICK_DIV * BLINK_TICKS;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = 2'd0;
  logic [15:0] cmd_color = 16'd0;
  logic [3:0]  cmd_count = 4'd0;
  logic        abort = 1'b0;
  logic [15:0] code;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  led_seq #(.TICK_DIV(TICK_DIV), .BLINK_TICKS(BLINK_TICKS)) dut (
    .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_color(cmd_color), .cmd_count(cmd_count),
    .abort(abort), .code(code), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [18:0] exp_q[$];   // {cmd_ready, busy, done, code}
  logic [18:0] tr_q[$];    // trace of the command being issued
  logic [18:0] mon_e;
  logic [15:0] steady_code = 16'd0;
  logic [15:0] exp_steady;

  function automatic logic [18:0] pk(input logic r, input logic b, input logic d,
                                     input logic [15:0] c);
    return {r, b, d, c};
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if ({cmd_ready, busy, done, code} !== mon_e) begin
          errors++;
          $display("FAIL out_cycle t=%0t: got ready=%0b busy=%0b done=%0b code=%h, expected ready=%0b busy=%0b done=%0b code=%h",
                   $time, cmd_ready, busy, done, code, mon_e[18], mon_e[17], mon_e[16], mon_e[15:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Expected outputs after each edge, starting with the accept edge.
  task automatic build_trace(input logic [1:0] m, input logic [15:0] c, input logic [3:0] n);
    int reps;
    int tr, tg, mx;
    logic [15:0] v_q[$];
    tr_q.delete();
    reps = (n == 4'd0) ? 16 : int'(n);
    exp_steady = 16'd0;
    if (m == 2'd0) begin
      tr_q.push_back(pk(1, 0, 1, 16'd0));
    end else if (m == 2'd2) begin
      for (int r = 0; r < reps; r++) begin
        for (int i = 0; i < PHASE; i++) tr_q.push_back(pk(0, 1, 0, c));
        for (int i = 0; i < PHASE; i++) tr_q.push_back(pk(0, 1, 0, 16'd0));
      end
      tr_q.push_back(pk(1, 0, 1, 16'd0));
`ifdef LED_SEQ_FADE_EN
    end else if (m == 2'd3) begin
      tr = int'(c[15:8]);
      tg = int'(c[7:0]);
      mx = imax(imax(tr, tg), 1);
      for (int r = 0; r < reps; r++) begin
        for (int t = 1; t <= mx; t++)
          v_q.push_back({8'(imin(t, tr)), 8'(imin(t, tg))});
        for (int t = 1; t <= mx; t++)
          v_q.push_back({8'(imax(tr - t, 0)), 8'(imax(tg - t, 0))});
      end
      for (int i = 0; i < TICK_DIV; i++) tr_q.push_back(pk(0, 1, 0, 16'd0));
      for (int j = 0; j < v_q.size() - 1; j++)
        for (int i = 0; i < TICK_DIV; i++) tr_q.push_back(pk(0, 1, 0, v_q[j]));
      tr_q.push_back(pk(1, 0, 1, 16'd0));
`endif
    end else begin
      tr_q.push_back(pk(1, 0, 1, c));
      exp_steady = c;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic v, input logic a, input logic [1:0] m,
                          input logic [15:0] c, input logic [3:0] n, input logic [18:0] e);
    @(negedge clock);
    cmd_valid = v;
    abort     = a;
    cmd_mode  = m;
    cmd_color = c;
    cmd_count = n;
    exp_q.push_back(e);
  endtask

  // Random command lines; only meaningful while the block is not ready or abort is high.
  task automatic noise_cycle(input logic a, input logic [18:0] e);
    do_cycle(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 16'($urandom),
             4'($urandom_range(0, 15)), e);
  endtask

  task automatic gap_cycle(input bit ab);
    if (ab) begin
      steady_code = 16'd0;
      noise_cycle(1'b1, pk(1, 0, 0, 16'd0));
    end else begin
      do_cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 4'd0,
               pk(1, 0, 0, steady_code));
    end
  endtask

  // abort_k: 0 = run to completion, >0 = abort before that trace index, -1 = random.
  task automatic run_cmd(input logic [1:0] m, input logic [15:0] c, input logic [3:0] n,
                         input int abort_k);
    int k;
    build_trace(m, c, n);
    k = abort_k;
    if (abort_k < 0) k = (tr_q.size() > 1) ? $urandom_range(1, tr_q.size() - 1) : 0;
    do_cycle(1'b1, 1'b0, m, c, n, tr_q[0]);
    for (int i = 1; i < tr_q.size(); i++) begin
      if (i == k) begin
        noise_cycle(1'b1, pk(1, 0, 0, 16'd0));
        steady_code = 16'd0;
        return;
      end
      noise_cycle(1'b0, tr_q[i]);
    end
    steady_code = exp_steady;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  m;
    logic [15:0] c;
    logic [3:0]  n;

    resetn = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_code", 32'(code), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'h1);

    run_cmd(2'd1, 16'h80FF, 4'd0, 0);
    repeat (3) gap_cycle(0);
    run_cmd(2'd2, 16'h00FF, 4'd2, 0);
    repeat (2) gap_cycle(0);
    run_cmd(2'd3, 16'h0302, 4'd1, 0);
    repeat (2) gap_cycle(0);
    run_cmd(2'd3, 16'h1234, 4'd1, 0);   // plain SOLID unless FADE is built
    gap_cycle(1);
    run_cmd(2'd3, 16'h0000, 4'd3, 0);
    gap_cycle(0);
    run_cmd(2'd2, 16'h00FF, 4'd0, 4 * PHASE + 2);   // abort inside third BLINK_ON
    repeat (2) gap_cycle(0);
    run_cmd(2'd2, 16'h0A0B, 4'd0, 0);   // full 16 repetitions
    run_cmd(2'd1, 16'h1111, 4'd0, 0);
    run_cmd(2'd2, 16'h2222, 4'd1, 0);   // replaces SOLID directly
    run_cmd(2'd0, 16'hFFFF, 4'd3, 0);
    gap_cycle(0);

    // Asynchronous reset in the middle of an effect.
`ifdef LED_SEQ_FADE_EN
    build_trace(2'd3, 16'h0302, 4'd1);
    do_cycle(1'b1, 1'b0, 2'd3, 16'h0302, 4'd1, tr_q[0]);
`else
    build_trace(2'd2, 16'h00FF, 4'd1);
    do_cycle(1'b1, 1'b0, 2'd2, 16'h00FF, 4'd1, tr_q[0]);
`endif
    for (int i = 1; i <= 5; i++) noise_cycle(1'b0, tr_q[i]);
    @(posedge clock);
    #2;
    cmd_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("async_reset_code", 32'(code), 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    chk("async_reset_done", 32'(done), 32'h0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    steady_code = 16'd0;
    repeat (4) gap_cycle(0);

    // Randomized commands.
    for (int t = 0; t < 60; t++) begin
      m = 2'($urandom_range(0, 3));
      c = 16'($urandom);
      if (m == 2'd3) c = {5'd0, 3'($urandom_range(0, 5)), 5'd0, 3'($urandom_range(0, 5))};
      n = 4'($urandom_range(0, 4));
      run_cmd(m, c, n, ($urandom_range(0, 3) == 0) ? -1 : 0);
      repeat ($urandom_range(0, 3)) gap_cycle($urandom_range(0, 6) == 0);
    end

    repeat (3) @(posedge clock);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq.md
LED_SEQ -- requirements
Module: led_seq

Interface
Parameters:
REQ-001 TICK_DIV, 50000, clock cycles per effect tick (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 BLINK_TICKS, 250, ticks per blink half-period; legal range 1..2^16-1.

Ports (clock and reset first):
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_mode  input  2  0=OFF, 1=SOLID, 2=BLINK, 3=FADE.
REQ-008 cmd_color  input  16  target code: [15:8] red, [7:0] green.
REQ-009 cmd_count  input  4  repetitions for BLINK/FADE; 0 means 16.
REQ-010 abort  input  1  cancel current effect.
REQ-011 code  output  16  registered PWM codeword for the downstream led stage; same field layout as cmd_color.
REQ-012 busy  output  1  high in any state other than IDLE or SOLID.
REQ-013 done  output  1  one-cycle pulse on effect completion.

Function
REQ-014 States SHALL be IDLE, SOLID, BLINK_ON, BLINK_OFF, FADE_UP, FADE_DOWN.
REQ-015 cmd_ready SHALL be 1 exactly in IDLE and SOLID; a command is accepted on a rising edge with cmd_valid and cmd_ready both 1, and mode, color and count are latched then.
REQ-016 Tick generator: free-running counter 0..TICK_DIV-1 emitting a one-cycle tick at TICK_DIV-1; cleared to 0 on every accept.
REQ-017 OFF accept: code=0 and state=IDLE the next cycle; done pulses that same cycle.
REQ-018 SOLID accept: code=cmd_color the next cycle; state SOLID; done pulses once that cycle; code holds until the next accept or abort.
REQ-019 BLINK accept: code=color, state BLINK_ON; after BLINK_TICKS ticks go to BLINK_OFF with code=0; after BLINK_TICKS more ticks one repetition is complete.
REQ-020 BLINK: after the final repetition's BLINK_OFF, go to IDLE with code=0 and pulse done; otherwise return to BLINK_ON with code=color.
REQ-021 FADE accept: code=0, state FADE_UP; on each tick every channel below its target increments by 1.
REQ-022 FADE_UP ends when both channels equal their targets: go to FADE_DOWN, where each nonzero channel decrements by 1 per tick.
REQ-023 FADE_DOWN ends when code=0: one repetition is complete; on the last repetition go to IDLE and pulse done, else re-enter FADE_UP.
REQ-024 FADE with a target channel of 0 SHALL keep that channel at 0; a target of 0x0000 completes each repetition in 2 ticks (one tick per phase).
REQ-025 Channel arithmetic is 8-bit unsigned per channel with no carry between red and green; channels never exceed their targets or go below 0.
REQ-026 Repetition counter is 5-bit and loaded with 16 when cmd_count=0.
REQ-027 abort SHALL override all other inputs: the next cycle gives state=IDLE, code=0, tick counter=0, no done pulse; a cmd_valid in the same cycle is not accepted.
REQ-028 A command accepted while in SOLID replaces the effect immediately, with no done pulse for the replaced SOLID.
REQ-029 done and abort SHALL never be high in the same cycle.

Reset
REQ-030 While resetn=0: state=IDLE, code=0x0000, done=0, busy=0, tick counter=0, repetition counter=0; cmd_ready=1 once reset is released.
REQ-031 Reset asserted mid-effect SHALL discard the effect with no done pulse; outputs reach reset values asynchronously.

Configuration
REQ-032 Macro LED_SEQ_FADE_EN defined: FADE behaves per REQ-021..REQ-025.
REQ-033 Macro LED_SEQ_FADE_EN undefined: FADE_UP/FADE_DOWN logic is absent and cmd_mode=3 behaves exactly as SOLID (REQ-018).

Verification (bench: TICK_DIV=4, BLINK_TICKS=2)
REQ-034 SOLID, color 0x80FF -> code=0x80FF the cycle after accept, single done pulse, busy=0, cmd_ready=1.
REQ-035 BLINK, color 0x00FF, count 2 -> code 0x00FF for 8 cycles, 0 for 8, 0x00FF for 8, 0 for 8; then done pulse, IDLE.
REQ-036 FADE, color 0x0302, count 1 -> code per tick: 0101, 0202, 0302, 0201, 0100, 0000; then done; 6 ticks = 24 cycles.
REQ-037 BLINK count 0, abort in the third BLINK_ON -> next cycle code=0, IDLE, no done; total count-0 run without abort is 16 repetitions.
REQ-038 resetn low during FADE_UP with code=0x0101 -> code=0 immediately (async), no done after release.
REQ-039 LED_SEQ_FADE_EN undefined, FADE with color 0x1234 -> code=0x1234 the cycle after accept, done pulse, state SOLID.
